alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Two-stage issue/retire pipeline directly upstream of the 32-bit combinational `alu`. It accepts register-addressed ALU commands over a valid/ready handshake and reads operands from an internal 8x32 register file, forwarding from in-flight results. It drives the ALU's `A`/`B`/`ALU_S` from registers, captures `Y`/`Zero`/`Carryout` one cycle later, and retires results with write-back and architectural flag update.

## Interface
Parameters:
- `NREGS`, 8: register count; index width is `$clog2(NREGS)` = 3.
- `W`, 32: datapath width; must match the ALU.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake; a command is accepted on an edge where both are 1.
- `cmd_op` in 3: opcode. 0 SUB, 1 CMP, 2 ADD, 3 AND, 4 XOR, 5 LI, 6/7 NOP.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2` in 3 each: destination and source register indices.
- `cmd_imm` in W: immediate; used only by LI.
- `alu_a`, `alu_b` out W; `alu_s` out 4: registered operands and select to the ALU.
- `alu_y` in W; `alu_zero` in 1; `alu_carry` in 1: ALU results, combinational from `alu_a`/`alu_b`/`alu_s`.
- `res_valid` out 1, `res_ready` in 1: retire handshake.
- `res_rd` out 3, `res_we` out 1, `res_data` out W: retiring result.
- `flag_z`, `flag_c` out 1: architectural flags.

## Operation
Opcode decode sets `alu_s`, A, B, `we` and `fl` (flag update):
- SUB: 0000, A=R[rs1], B=R[rs2], we=1, fl=1.
- CMP: 0001, A=R[rs1], B=R[rs2], we=0, fl=1.
- ADD: 0010, A=R[rs1], B=R[rs2], we=1, fl=1.
- AND: 0011, A=R[rs1], B=R[rs2], we=1, fl=1.
- XOR: 0100, A=R[rs1], B=R[rs2], we=1, fl=1.
- LI: 0010, A=imm, B=0, we=1, fl=0.
- NOP (op 6/7): 0000, A=B=0, we=0, fl=0.

Register file:
- R0 always reads 0. A write to R0 has `res_we` = 1 on the port but the array is not written.

Pipeline:
- S1 holds the operand registers (the `alu_*` outputs) plus valid, rd, we and fl.
- S2 holds the captured `alu_y`, `alu_zero`, `alu_carry` plus valid, rd, we and fl.
- `res_*` are driven from S2.

Operand read happens at command accept. Source priority, applied per operand:
1. S1 valid, S1.we, S1.rd == rs, rs != 0: use `alu_y` (combinational forward).
2. Otherwise S2 valid, S2.we, S2.rd == rs, rs != 0: use S2 data.
3. Otherwise the register file.

Retire happens on an edge where `res_valid` && `res_ready`:
- If `we` and rd != 0, R[rd] is written with S2 data.
- If `fl`, `flag_z` takes S2 zero and `flag_c` takes S2 carry.
- `flag_c` stores the ALU `Carryout` verbatim, which is the unsigned A+B carry for every opcode.

Stall rules:
- `s2_adv = !S2.valid || res_ready`
- `s1_adv = !S1.valid || s2_adv`
- `cmd_ready = s1_adv`, driven combinationally without depending on `cmd_valid`.
- S2 loads from S1 when `s2_adv`. S1 loads from the command when `s1_adv`.
- A stage with nothing to load clears its valid.
- Stalled stages hold every field, so the ALU inputs and `alu_y` stay stable.

Reset (asynchronous) clears:
- Both valids, all register-file entries, and both flags.
- `alu_a`, `alu_b`, and `alu_s` (to 0000).
- All S2 fields.
- After reset, `res_valid` = 0 and `cmd_ready` = 1.
- Reset mid-operation discards in-flight commands with no write-back.

## Timing
- Latency: a command accepted at edge k has `res_valid` = 1 in the cycle after edge k+1, provided S2 was not stalled.
- Throughput: one command per cycle while `res_ready` = 1.
- Back-to-back dependent commands need no bubbles. A dependency on the immediately preceding command uses the `alu_y` forward.
- Same-edge retire and read of the same register: S2 data is forwarded, never stale register-file data.
- Once asserted, `res_valid` holds until accepted, and `res_*` stay stable meanwhile.

## Structure
- Package `alu_pkg`:
  - opcode enum `alu_op_e`;
  - ALU select constants `ALU_SUB` = 4'b0000, `ALU_CMP` = 4'b0001, `ALU_ADD` = 4'b0010, `ALU_AND` = 4'b0011, `ALU_XOR` = 4'b0100;
  - a decode function returning alu_s, we and fl.
- Sub-module `alu_regfile`: NREGS x W, two combinational read ports, one synchronous write port, R0 tied to zero, async reset.
- For testing, the ALU is instantiated alongside this block in the bench; it is not instantiated inside it.

## Test plan
- Reset then idle: after `rst` pulse, `cmd_ready` = 1, `res_valid` = 0, `flag_z` = `flag_c` = 0, `alu_s` = 0000.
- LI then dependent ADD: LI R1,5; LI R2,7; ADD R3,R1,R2 on consecutive cycles.
  - Required: R3 result 12, `flag_z` = 0, `flag_c` = 0.
  - ADD operands must be forwarded (R1 from S2, R2 from `alu_y`).
- CMP equal: R1=R2=0xFFFF_FFFF, CMP R0,R1,R2.
  - Required: `res_we` = 0, `flag_z` = 1, `flag_c` = 1 (A+B carry); no register changes.
- Backpressure: hold `res_ready` = 0 with three commands issued.
  - Required: `cmd_ready` drops after two accepts, and `res_*` stay stable.
  - Releasing `res_ready` retires results in order with no loss or duplication.
- R0 and NOP: LI R0,9 then ADD R4,R0,R0.
  - Required: R4 = 0. A NOP retires with `res_we` = 0 and flags unchanged.
- Reset mid-flight: async `rst` while S1 and S2 are valid.
  - Required: `res_valid` falls immediately, no write-back occurs, and all registers read 0 afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and decode for the ALU issue stage.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_SUB  = 3'd0,
        OP_CMP  = 3'd1,
        OP_ADD  = 3'd2,
        OP_AND  = 3'd3,
        OP_XOR  = 3'd4,
        OP_LI   = 3'd5,
        OP_NOP6 = 3'd6,
        OP_NOP7 = 3'd7
    } alu_op_e;

    localparam logic [3:0] ALU_SUB = 4'b0000;
    localparam logic [3:0] ALU_CMP = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;

    typedef struct packed {
        logic [3:0] alu_s;
        logic       we;
        logic       fl;
    } alu_dec_t;

    // Opcode to ALU select, write-enable and flag-update. LI rides the adder with B=0.
    function automatic alu_dec_t alu_decode(input alu_op_e op);
        alu_dec_t d;
        d.alu_s = ALU_SUB;
        d.we    = 1'b0;
        d.fl    = 1'b0;
        case (op)
            OP_SUB: begin d.alu_s = ALU_SUB; d.we = 1'b1; d.fl = 1'b1; end
            OP_CMP: begin d.alu_s = ALU_CMP; d.we = 1'b0; d.fl = 1'b1; end
            OP_ADD: begin d.alu_s = ALU_ADD; d.we = 1'b1; d.fl = 1'b1; end
            OP_AND: begin d.alu_s = ALU_AND; d.we = 1'b1; d.fl = 1'b1; end
            OP_XOR: begin d.alu_s = ALU_XOR; d.we = 1'b1; d.fl = 1'b1; end
            OP_LI:  begin d.alu_s = ALU_ADD; d.we = 1'b1; d.fl = 1'b0; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x W register file: two combinational reads, one synchronous write, R0 hard-wired to zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int W     = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [W-1:0]  rd1,
    output logic [W-1:0]  rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd
);

    logic [W-1:0] mem_q [NREGS];
    logic [W-1:0] mem_d [NREGS];

    // Next-state of the array; entry 0 is kept at zero so writes to R0 are dropped.
    always_comb begin
        mem_d = mem_q;
        if (we && (wa != '0)) begin
            mem_d[wa] = wd;
        end
        mem_d[0] = '0;
    end

    // Array storage with async clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : mem_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : mem_q[ra2];

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage issue/retire pipeline feeding an external combinational ALU.
// S1 holds the registered ALU inputs; S2 captures the ALU result and retires it.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int W     = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [W-1:0]  cmd_imm,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_s,
    input  logic [W-1:0]  alu_y,
    input  logic          alu_zero,
    input  logic          alu_carry,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_rd,
    output logic          res_we,
    output logic [W-1:0]  res_data,
    output logic          flag_z,
    output logic          flag_c
);

    logic          s1_valid_q, s1_valid_d, s1_we_q, s1_we_d, s1_fl_q, s1_fl_d;
    logic [AW-1:0] s1_rd_q, s1_rd_d;
    logic [W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]    alu_s_q, alu_s_d;

    logic          s2_valid_q, s2_valid_d, s2_we_q, s2_we_d, s2_fl_q, s2_fl_d;
    logic          s2_z_q, s2_z_d, s2_c_q, s2_c_d;
    logic [AW-1:0] s2_rd_q, s2_rd_d;
    logic [W-1:0]  s2_y_q, s2_y_d;

    logic          flag_z_q, flag_z_d, flag_c_q, flag_c_d;

    logic          s1_adv, s2_adv, retire;
    logic [W-1:0]  rf_rd1, rf_rd2, fwd_a, fwd_b;
    alu_dec_t      dec;

    assign s2_adv    = !s2_valid_q || res_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign retire    = s2_valid_q && res_ready;
    assign cmd_ready = s1_adv;

    alu_regfile #(.NREGS(NREGS), .W(W), .AW(AW)) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (cmd_rs1),
        .ra2 (cmd_rs2),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (retire && s2_we_q),
        .wa  (s2_rd_q),
        .wd  (s2_y_q)
    );

    // Operand fetch with forwarding: the younger S1 result wins over S2, which wins over the array.
    always_comb begin
        fwd_a = rf_rd1;
        fwd_b = rf_rd2;
        if (s2_valid_q && s2_we_q && (s2_rd_q == cmd_rs1) && (cmd_rs1 != '0)) fwd_a = s2_y_q;
        if (s2_valid_q && s2_we_q && (s2_rd_q == cmd_rs2) && (cmd_rs2 != '0)) fwd_b = s2_y_q;
        if (s1_valid_q && s1_we_q && (s1_rd_q == cmd_rs1) && (cmd_rs1 != '0)) fwd_a = alu_y;
        if (s1_valid_q && s1_we_q && (s1_rd_q == cmd_rs2) && (cmd_rs2 != '0)) fwd_b = alu_y;
    end

    // Stage advance, decode and retire; stalled stages hold every field.
    always_comb begin
        dec        = alu_decode(alu_op_e'(cmd_op));
        s1_valid_d = s1_valid_q;
        s1_we_d    = s1_we_q;
        s1_fl_d    = s1_fl_q;
        s1_rd_d    = s1_rd_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_s_d    = alu_s_q;
        s2_valid_d = s2_valid_q;
        s2_we_d    = s2_we_q;
        s2_fl_d    = s2_fl_q;
        s2_rd_d    = s2_rd_q;
        s2_y_d     = s2_y_q;
        s2_z_d     = s2_z_q;
        s2_c_d     = s2_c_q;
        flag_z_d   = flag_z_q;
        flag_c_d   = flag_c_q;

        if (s1_adv) begin
            s1_valid_d = cmd_valid;
            if (cmd_valid) begin
                s1_we_d = dec.we;
                s1_fl_d = dec.fl;
                s1_rd_d = cmd_rd;
                alu_s_d = dec.alu_s;
                case (alu_op_e'(cmd_op))
                    OP_LI:                begin alu_a_d = cmd_imm; alu_b_d = '0;    end
                    OP_NOP6, OP_NOP7:     begin alu_a_d = '0;      alu_b_d = '0;    end
                    default:              begin alu_a_d = fwd_a;   alu_b_d = fwd_b; end
                endcase
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_we_d = s1_we_q;
                s2_fl_d = s1_fl_q;
                s2_rd_d = s1_rd_q;
                s2_y_d  = alu_y;
                s2_z_d  = alu_zero;
                s2_c_d  = alu_carry;
            end
        end

        if (retire && s2_fl_q) begin
            flag_z_d = s2_z_q;
            flag_c_d = s2_c_q;
        end
    end

    // Pipeline and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_we_q    <= 1'b0;
            s1_fl_q    <= 1'b0;
            s1_rd_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_s_q    <= ALU_SUB;
            s2_valid_q <= 1'b0;
            s2_we_q    <= 1'b0;
            s2_fl_q    <= 1'b0;
            s2_rd_q    <= '0;
            s2_y_q     <= '0;
            s2_z_q     <= 1'b0;
            s2_c_q     <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_we_q    <= s1_we_d;
            s1_fl_q    <= s1_fl_d;
            s1_rd_q    <= s1_rd_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_s_q    <= alu_s_d;
            s2_valid_q <= s2_valid_d;
            s2_we_q    <= s2_we_d;
            s2_fl_q    <= s2_fl_d;
            s2_rd_q    <= s2_rd_d;
            s2_y_q     <= s2_y_d;
            s2_z_q     <= s2_z_d;
            s2_c_q     <= s2_c_d;
            flag_z_q   <= flag_z_d;
            flag_c_q   <= flag_c_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign res_valid = s2_valid_q;
    assign res_rd    = s2_rd_q;
    assign res_we    = s2_we_q;
    assign res_data  = s2_y_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU alongside the DUT, an in-order
// architectural model with an expected-retire queue, directed and random stimulus.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op, cmd_rd, cmd_rs1, cmd_rs2;
    logic [31:0] cmd_imm;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [3:0]  alu_s;
    logic        alu_zero, alu_carry;
    logic        res_valid, res_ready, res_we;
    logic [2:0]  res_rd;
    logic [31:0] res_data;
    logic        flag_z, flag_c;

    always #5 clk = ~clk;

    alu_issue_stage #(.NREGS(8), .W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_y     (alu_y),
        .alu_zero  (alu_zero),
        .alu_carry (alu_carry),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_rd    (res_rd),
        .res_we    (res_we),
        .res_data  (res_data),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    // Behavioural ALU standing in for the real one.
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        case (alu_s)
            4'b0000, 4'b0001: alu_y = alu_a - alu_b;
            4'b0010:          alu_y = alu_sum[31:0];
            4'b0011:          alu_y = alu_a & alu_b;
            4'b0100:          alu_y = alu_a ^ alu_b;
            default:          alu_y = 32'h0;
        endcase
        alu_zero  = (alu_y == 32'h0);
        alu_carry = alu_sum[32];
    end

    // ---------------- model ----------------
    typedef struct {
        logic [2:0]  rd;
        logic        we;
        logic        fl;
        logic [31:0] y;
        logic        z;
        logic        c;
        int          acc_cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mregs [8];
    logic        mz, mc;
    int          cyc;
    int          n_checks, n_fail;
    logic [31:0] last_data;
    logic        last_we;
    logic [2:0]  last_rd;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        for (int i = 0; i < 8; i++) mregs[i] = 32'h0;
        mz = 1'b0;
        mc = 1'b0;
    endfunction

    // Sequential-ISA semantics: each accepted command sees all earlier ones applied.
    function automatic void model_accept(logic [2:0] op, logic [2:0] rd, logic [2:0] rs1,
                                         logic [2:0] rs2, logic [31:0] imm);
        exp_t e;
        logic [31:0] a, b;
        logic [32:0] s;
        a = (rs1 == 3'd0) ? 32'h0 : mregs[rs1];
        b = (rs2 == 3'd0) ? 32'h0 : mregs[rs2];
        e.we = 1'b1;
        e.fl = 1'b1;
        case (op)
            3'd0, 3'd1: e.y = a - b;
            3'd2:       e.y = a + b;
            3'd3:       e.y = a & b;
            3'd4:       e.y = a ^ b;
            3'd5: begin a = imm; b = 32'h0; e.y = imm; e.fl = 1'b0; end
            default: begin a = 32'h0; b = 32'h0; e.y = 32'h0; e.we = 1'b0; e.fl = 1'b0; end
        endcase
        if (op == 3'd1) e.we = 1'b0;
        s = {1'b0, a} + {1'b0, b};
        e.c = s[32];
        e.z = (e.y == 32'h0);
        e.rd = rd;
        e.acc_cyc = cyc;
        if (e.we && rd != 3'd0) mregs[rd] = e.y;
        q.push_back(e);
    endfunction

    function automatic void model_retire();
        exp_t e;
        e = q.pop_front();
        last_data = res_data;
        last_we   = res_we;
        last_rd   = res_rd;
        if (e.fl) begin
            mz = e.z;
            mc = e.c;
        end
    endfunction

    // Compare process body: every cycle, outputs against the model.
    function automatic void check_outputs();
        logic exp_rv, exp_cr;
        exp_rv = (q.size() > 0) && (q[0].acc_cyc != cyc - 1);
        exp_cr = !((q.size() >= 2) && !res_ready);
        chk("res_valid", {31'h0, res_valid}, {31'h0, exp_rv});
        chk("cmd_ready", {31'h0, cmd_ready}, {31'h0, exp_cr});
        if (exp_rv && res_valid) begin
            chk("res_rd",   {29'h0, res_rd}, {29'h0, q[0].rd});
            chk("res_we",   {31'h0, res_we}, {31'h0, q[0].we});
            chk("res_data", res_data, q[0].y);
        end
        chk("flag_z", {31'h0, flag_z}, {31'h0, mz});
        chk("flag_c", {31'h0, flag_c}, {31'h0, mc});
    endfunction

    int acc_count;

    task automatic step(input logic v, input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [31:0] imm, input logic rr);
        logic acc, ret;
        @(negedge clk);
        check_outputs();
        cmd_valid = v;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_imm   = imm;
        res_ready = rr;
        #1;
        acc = cmd_valid && cmd_ready;
        ret = res_valid && res_ready;
        if (ret) model_retire();
        if (acc) begin
            model_accept(op, rd, rs1, rs2, imm);
            acc_count++;
        end
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 3'd6, 3'd0, 3'd0, 3'd0, 32'h0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; acc_count = 0;
        last_data = 32'h0; last_we = 1'b0; last_rd = 3'd0;
        cmd_valid = 1'b0; cmd_op = 3'd6; cmd_rd = 3'd0; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0;
        cmd_imm = 32'h0; res_ready = 1'b0;
        model_reset();
        rst = 1'b1;
        #23;
        rst = 1'b0;

        // Reset then idle
        @(negedge clk);
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
        chk("rst_flag_z",    {31'h0, flag_z},    32'h0);
        chk("rst_flag_c",    {31'h0, flag_c},    32'h0);
        chk("rst_alu_s",     {28'h0, alu_s},     32'h0);

        // LI R1,5; LI R2,7; ADD R3,R1,R2 back to back
        step(1'b1, 3'd5, 3'd1, 3'd0, 3'd0, 32'd5, 1'b1);
        step(1'b1, 3'd5, 3'd2, 3'd0, 3'd0, 32'd7, 1'b1);
        step(1'b1, 3'd2, 3'd3, 3'd1, 3'd2, 32'h0, 1'b1);
        @(posedge clk); #1;
        chk("add_fwd_a", alu_a, 32'd5);
        chk("add_fwd_b", alu_b, 32'd7);
        drain();
        chk("add_r3_data", last_data, 32'd12);
        chk("add_r3_rd",   {29'h0, last_rd}, 32'd3);
        chk("add_flag_z",  {31'h0, flag_z}, 32'h0);
        chk("add_flag_c",  {31'h0, flag_c}, 32'h0);

        // CMP equal with all-ones operands
        step(1'b1, 3'd5, 3'd1, 3'd0, 3'd0, 32'hFFFF_FFFF, 1'b1);
        step(1'b1, 3'd5, 3'd2, 3'd0, 3'd0, 32'hFFFF_FFFF, 1'b1);
        step(1'b1, 3'd1, 3'd0, 3'd1, 3'd2, 32'h0, 1'b1);
        drain();
        chk("cmp_we",     {31'h0, last_we}, 32'h0);
        chk("cmp_flag_z", {31'h0, flag_z}, 32'h1);
        chk("cmp_flag_c", {31'h0, flag_c}, 32'h1);

        // NOP retires without write and leaves flags alone
        step(1'b1, 3'd7, 3'd5, 3'd1, 3'd2, 32'h0, 1'b1);
        drain();
        chk("nop_we",     {31'h0, last_we}, 32'h0);
        chk("nop_flag_z", {31'h0, flag_z}, 32'h1);
        chk("nop_flag_c", {31'h0, flag_c}, 32'h1);

        // R0 stays zero
        step(1'b1, 3'd5, 3'd0, 3'd0, 3'd0, 32'd9, 1'b1);
        step(1'b1, 3'd2, 3'd4, 3'd0, 3'd0, 32'h0, 1'b1);
        drain();
        chk("r0_add_r4", last_data, 32'h0);

        // Backpressure: three offered, two accepted, then release
        acc_count = 0;
        step(1'b1, 3'd2, 3'd5, 3'd1, 3'd2, 32'h0, 1'b0);
        step(1'b1, 3'd4, 3'd6, 3'd5, 3'd1, 32'h0, 1'b0);
        step(1'b1, 3'd3, 3'd7, 3'd6, 3'd5, 32'h0, 1'b0);
        step(1'b1, 3'd3, 3'd7, 3'd6, 3'd5, 32'h0, 1'b0);
        chk("bp_accepts", acc_count, 32'd2);
        drain();

        // Reset mid-flight with both stages occupied
        step(1'b1, 3'd5, 3'd5, 3'd0, 3'd0, 32'h55, 1'b0);
        step(1'b1, 3'd5, 3'd6, 3'd0, 3'd0, 32'h66, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_res_valid", {31'h0, res_valid}, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 1; k < 8; k++) step(1'b1, 3'd2, 3'd0, k[2:0], 3'd0, 32'h0, 1'b1);
        drain();
        chk("mid_rst_r7", last_data, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] imm;
            case ($urandom_range(0, 4))
                0: imm = 32'h0;
                1: imm = 32'h1;
                2: imm = 32'hFFFF_FFFF;
                3: imm = 32'h8000_0000;
                default: imm = $urandom;
            endcase
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), imm,
                 $urandom_range(0, 9) < 7);
        end
        drain();
        @(negedge clk);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
